v_pipe_update: RTL and testbench
================================

Name: v_pipe_update

Overview:
- Write-side counterpart of the list query pipeline. Accepts add/delete/replace/clear commands per product ID.
- Reads the per-ID state table entry, computes the new sorted list, and writes it back.
- Publishes the per-stage in-flight valid and ID signals that the query pipeline uses for its busy check.
- Six stages, S0–S5. Table read in S0, write in S4, response in S5.

Parameters:
- ENTRIES_N, 4, levels per list (equals cfg_pkg::ENTRIES_N).
- ID_BITS, 8, product ID width.
- KEY_BITS, 16, price key width.
- VOLUME_BITS, 16, volume width.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- i_upd_vld  in  1  command valid
- i_upd_prod_id  in  ID_BITS  target list
- i_upd_cmd  in  2  v_pkg::cmd_t: CLEAR=0, ADD=1, DELETE=2, REPLACE=3
- i_upd_key  in  KEY_BITS  level key
- i_upd_volume  in  VOLUME_BITS  level volume
- o_upd_rdy  out  1  command accepted when i_upd_vld & o_upd_rdy
- o_upd_rsp_vld_r  out  1  response valid
- o_upd_rsp_prod_id_r  out  ID_BITS  response ID
- o_upd_rsp_error_r  out  1  command rejected; table unchanged
- o_state_ren  out  1  state read enable
- o_state_raddr  out  ID_BITS  read address
- i_state_rdata  in  v_pkg::state_t  read data, valid one cycle after o_state_ren
- o_state_wen  out  1  write enable
- o_state_waddr  out  ID_BITS  write address
- o_state_wdata  out  v_pkg::state_t  write data: vld[N], key[N], volume[N], listsize
- o_sK_upd_vld_r, o_sK_upd_prod_id_r (K=1..5)  out  1 / ID_BITS  stage-K in-flight flags

Behaviour:
- Reset: all stage valids 0. o_upd_rsp_vld_r=0, o_state_wen=0, o_state_ren=0, all o_sK_upd_vld_r=0. Datapath flops are not reset.
- List invariant: vld is a thermometer code (valid prefix). Keys are strictly descending over valid levels. listsize = popcount(vld).
- Accept (S0): o_upd_rdy = ~(OR over K=1..4 of sK_vld & sK_id==i_upd_prod_id). This is combinational from the inputs.
  - On accept: o_state_ren=1, o_state_raddr=i_upd_prod_id, and S1 captures the command.
  - Pipeline never stalls after accept. One accept per cycle maximum.
- S1: capture i_state_rdata.
- S2: compute per-level compare vectors: gt[i] = vld[i] & key[i]>cmd_key; eq[i] = vld[i] & key[i]==cmd_key.
  - Insert position p = popcount(gt).
- S3: form the new state.
  - ADD:
    - any eq → error.
    - listsize==ENTRIES_N → error.
    - Otherwise shift levels p..N-2 down one, write level p, listsize+1.
  - DELETE: no eq → error. Otherwise shift levels above the match up one, clear top valid bit, listsize-1.
  - REPLACE: no eq → error. Otherwise overwrite volume at the match; keys and vld unchanged.
  - CLEAR: always succeeds. vld='0, listsize=0.
- S4: o_state_wen = s4_vld & ~s4_error. Write address and data come from flops.
- S5: o_upd_rsp_vld_r=1 with the ID and error. Latency is exactly 5 cycles from accept.
- Errored commands still occupy every stage and still drive o_sK_upd_vld_r.
- Same-ID back-to-back commands: the second is held off until the first leaves S4. Its S0 read then sees the written data.
- Different-ID commands issue every cycle.
- Reset mid-operation: in-flight commands are dropped with no write and no response. Table contents are undefined to software afterwards.

Optional Feature:
- Macro: V_PIPE_UPDATE_BYPASS_EN.
- When defined:
  - The stall window shrinks to S1..S3.
  - In S1, if S5 is valid, did not error, and s5_id==s1_id, the captured state is taken from the S5 copy of the written state instead of i_state_rdata.
  - This allows same-ID issue with 4-cycle spacing.
- When undefined: no S5 state copy, and the stall window is S1..S4.

Decomposition:
- v_pkg holds: cmd_t enum, id_t, key_t, volume_t, listsize_t, state_t struct, and ENTRIES_N via cfg_pkg.
- One sub-module: v_list_edit. It is purely combinational, takes state, cmd, key, volume and p/eq, and returns the new state and error. It is instantiated in S3.

Test Plan:
- Empty ID 3. ADD key=100 vol=5 → rsp at +5 cycles, err=0. wdata vld=0001, key[0]=100, listsize=1.
- ID 3 holds {100,90}. ADD key=95 vol=7 → keys {100,95,90}, vld=0111, listsize=3. Then ADD key=95 → err=1, wen=0.
- Full list {100,90,80,70}. ADD key=85 → err=1. DELETE key=90 → {100,80,70}, vld=0111, listsize=3.
- REPLACE key=80 vol=9 on ID 3 → volume[1]=9. REPLACE key=55 → err=1.
- Same-ID collision: ADD ID 3 at cycle 0, then i_upd_vld held with ID 3. o_upd_rdy=0 for cycles 1..4 (1..3 with bypass) and the second command is accepted on the first ready cycle. ID 4 on cycle 1 is accepted immediately.
- Assert arst while 3 commands are in flight → no wen and no rsp. All o_sK_upd_vld_r=0 next cycle. CLEAR ID 3 afterwards → listsize=0, err=0.

Source files
------------

// File: rtl/v_pipe_update_pkg.sv
// Shared configuration and types for the list update pipeline: command encoding,
// field widths and the per-ID state table entry layout.
package cfg_pkg;
  localparam int ENTRIES_N = 4;
endpackage

package v_pkg;
  localparam int ENTRIES_N   = cfg_pkg::ENTRIES_N;
  localparam int ID_BITS     = 8;
  localparam int KEY_BITS    = 16;
  localparam int VOLUME_BITS = 16;
  localparam int LS_BITS     = $clog2(ENTRIES_N + 1);

  typedef enum logic [1:0] {
    CMD_CLEAR   = 2'd0,
    CMD_ADD     = 2'd1,
    CMD_DELETE  = 2'd2,
    CMD_REPLACE = 2'd3
  } cmd_t;

  typedef logic [ID_BITS-1:0]     id_t;
  typedef logic [KEY_BITS-1:0]    key_t;
  typedef logic [VOLUME_BITS-1:0] volume_t;
  typedef logic [LS_BITS-1:0]     listsize_t;

  // Level 0 holds the highest key; vld is a valid prefix starting at level 0.
  typedef struct packed {
    logic [ENTRIES_N-1:0]    vld;
    key_t [ENTRIES_N-1:0]    key;
    volume_t [ENTRIES_N-1:0] volume;
    listsize_t               listsize;
  } state_t;
endpackage

// File: rtl/v_list_edit.sv
// Combinational list editor: applies one command at insert/match position pos,
// returning the new state and an error flag (state passes through on error).
module v_list_edit
  import v_pkg::*;
(
  input  state_t               state,
  input  cmd_t                 cmd,
  input  key_t                 key,
  input  volume_t              volume,
  input  listsize_t            pos,
  input  logic [ENTRIES_N-1:0] eq,
  output state_t               new_state,
  output logic                 error
);

  always_comb begin
    new_state = state;
    error     = 1'b0;
    case (cmd)
      CMD_ADD: begin
        if ((|eq) || (state.listsize == listsize_t'(ENTRIES_N))) begin
          error = 1'b1;
        end else begin
          for (int i = 1; i < ENTRIES_N; i++) begin
            if (listsize_t'(i) > pos) begin
              new_state.key[i]    = state.key[i-1];
              new_state.volume[i] = state.volume[i-1];
            end
          end
          for (int i = 0; i < ENTRIES_N; i++) begin
            if (listsize_t'(i) == pos) begin
              new_state.key[i]    = key;
              new_state.volume[i] = volume;
            end
          end
          new_state.vld      = {state.vld[ENTRIES_N-2:0], 1'b1};
          new_state.listsize = state.listsize + 1'b1;
        end
      end
      // With strictly descending keys the match index equals the count of larger keys.
      CMD_DELETE: begin
        if (!(|eq)) begin
          error = 1'b1;
        end else begin
          for (int i = 0; i < ENTRIES_N - 1; i++) begin
            if (listsize_t'(i) >= pos) begin
              new_state.key[i]    = state.key[i+1];
              new_state.volume[i] = state.volume[i+1];
            end
          end
          new_state.vld      = state.vld >> 1;
          new_state.listsize = state.listsize - 1'b1;
        end
      end
      CMD_REPLACE: begin
        if (!(|eq)) begin
          error = 1'b1;
        end else begin
          for (int i = 0; i < ENTRIES_N; i++) begin
            if (listsize_t'(i) == pos) new_state.volume[i] = volume;
          end
        end
      end
      CMD_CLEAR: begin
        new_state.vld      = '0;
        new_state.listsize = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/v_pipe_update.sv
// Six-stage list update pipeline (read S0, write S4, response S5, 5-cycle latency); same-ID
// commands are held off while in S1..S4, or S1..S3 with V_PIPE_UPDATE_BYPASS_EN defined.
module v_pipe_update
  import v_pkg::*;
(
  input  logic    clk,
  input  logic    arst,
  input  logic    i_upd_vld,
  input  id_t     i_upd_prod_id,
  input  cmd_t    i_upd_cmd,
  input  key_t    i_upd_key,
  input  volume_t i_upd_volume,
  output logic    o_upd_rdy,
  output logic    o_upd_rsp_vld_r,
  output id_t     o_upd_rsp_prod_id_r,
  output logic    o_upd_rsp_error_r,
  output logic    o_state_ren,
  output id_t     o_state_raddr,
  input  state_t  i_state_rdata,
  output logic    o_state_wen,
  output id_t     o_state_waddr,
  output state_t  o_state_wdata,
  output logic    o_s1_upd_vld_r,
  output id_t     o_s1_upd_prod_id_r,
  output logic    o_s2_upd_vld_r,
  output id_t     o_s2_upd_prod_id_r,
  output logic    o_s3_upd_vld_r,
  output id_t     o_s3_upd_prod_id_r,
  output logic    o_s4_upd_vld_r,
  output id_t     o_s4_upd_prod_id_r,
  output logic    o_s5_upd_vld_r,
  output id_t     o_s5_upd_prod_id_r
);

`ifdef V_PIPE_UPDATE_BYPASS_EN
  localparam int STALL_LAST = 3;
`else
  localparam int STALL_LAST = 4;
`endif

  logic [5:1]           vld_q;
  id_t                  id_q [1:5];
  cmd_t                 s1_cmd, s2_cmd, s3_cmd;
  key_t                 s1_key, s2_key, s3_key;
  volume_t              s1_volume, s2_volume, s3_volume;
  state_t               s1_state, s2_state, s3_state, s4_state;
  logic [ENTRIES_N-1:0] s2_gt, s2_eq, s3_eq;
  listsize_t            s2_pos, s3_pos;
  state_t               edit_state;
  logic                 edit_error;
  logic                 s4_error, s5_error;
  logic                 busy, accept;

  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= STALL_LAST; k++) begin
      if (vld_q[k] && (id_q[k] == i_upd_prod_id)) busy = 1'b1;
    end
  end

  assign o_upd_rdy     = ~busy;
  assign accept        = i_upd_vld & ~busy;
  assign o_state_ren   = accept;
  assign o_state_raddr = i_upd_prod_id;

`ifdef V_PIPE_UPDATE_BYPASS_EN
  state_t s5_state;

  // The table write from S4 lands on the same edge as this command's read, so forward it.
  assign s1_state = (vld_q[5] && !s5_error && (id_q[5] == id_q[1])) ? s5_state : i_state_rdata;

  always_ff @(posedge clk) s5_state <= s4_state;
`else
  assign s1_state = i_state_rdata;
`endif

  always_comb begin
    s2_gt  = '0;
    s2_eq  = '0;
    s2_pos = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      s2_gt[i] = s2_state.vld[i] && (s2_state.key[i] > s2_key);
      s2_eq[i] = s2_state.vld[i] && (s2_state.key[i] == s2_key);
      s2_pos   = s2_pos + listsize_t'(s2_gt[i]);
    end
  end

  v_list_edit u_list_edit (
    .state     (s3_state),
    .cmd       (s3_cmd),
    .key       (s3_key),
    .volume    (s3_volume),
    .pos       (s3_pos),
    .eq        (s3_eq),
    .new_state (edit_state),
    .error     (edit_error)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) vld_q <= '0;
    else      vld_q <= {vld_q[4:1], accept};
  end

  always_ff @(posedge clk) begin
    id_q[1] <= i_upd_prod_id;
    for (int k = 2; k <= 5; k++) id_q[k] <= id_q[k-1];
    s1_cmd    <= i_upd_cmd;
    s1_key    <= i_upd_key;
    s1_volume <= i_upd_volume;
    s2_cmd    <= s1_cmd;
    s2_key    <= s1_key;
    s2_volume <= s1_volume;
    s2_state  <= s1_state;
    s3_cmd    <= s2_cmd;
    s3_key    <= s2_key;
    s3_volume <= s2_volume;
    s3_state  <= s2_state;
    s3_pos    <= s2_pos;
    s3_eq     <= s2_eq;
    s4_state  <= edit_state;
    s4_error  <= edit_error;
    s5_error  <= s4_error;
  end

  assign o_state_wen   = vld_q[4] & ~s4_error;
  assign o_state_waddr = id_q[4];
  assign o_state_wdata = s4_state;

  assign o_upd_rsp_vld_r     = vld_q[5];
  assign o_upd_rsp_prod_id_r = id_q[5];
  assign o_upd_rsp_error_r   = s5_error;

  assign o_s1_upd_vld_r     = vld_q[1];
  assign o_s1_upd_prod_id_r = id_q[1];
  assign o_s2_upd_vld_r     = vld_q[2];
  assign o_s2_upd_prod_id_r = id_q[2];
  assign o_s3_upd_vld_r     = vld_q[3];
  assign o_s3_upd_prod_id_r = id_q[3];
  assign o_s4_upd_vld_r     = vld_q[4];
  assign o_s4_upd_prod_id_r = id_q[4];
  assign o_s5_upd_vld_r     = vld_q[5];
  assign o_s5_upd_prod_id_r = id_q[5];

endmodule

// File: tb/tb_v_pipe_update.sv
// Bench for v_pipe_update: state table RAM, queue-based list model and per-cycle scoreboard.
module tb_v_pipe_update;
  import v_pkg::*;

`ifdef V_PIPE_UPDATE_BYPASS_EN
  localparam int STALL_LAST = 3;
`else
  localparam int STALL_LAST = 4;
`endif

  logic    clk, arst;
  logic    upd_vld, upd_rdy;
  id_t     upd_id;
  cmd_t    upd_cmd;
  key_t    upd_key;
  volume_t upd_vol;
  logic    rsp_vld, rsp_err;
  id_t     rsp_id;
  logic    ren, wen;
  id_t     raddr, waddr;
  state_t  rdata, wdata;
  logic [5:1] s_vld;
  id_t     s_id [1:5];

  v_pipe_update dut (
    .clk(clk), .arst(arst),
    .i_upd_vld(upd_vld), .i_upd_prod_id(upd_id), .i_upd_cmd(upd_cmd),
    .i_upd_key(upd_key), .i_upd_volume(upd_vol), .o_upd_rdy(upd_rdy),
    .o_upd_rsp_vld_r(rsp_vld), .o_upd_rsp_prod_id_r(rsp_id), .o_upd_rsp_error_r(rsp_err),
    .o_state_ren(ren), .o_state_raddr(raddr), .i_state_rdata(rdata),
    .o_state_wen(wen), .o_state_waddr(waddr), .o_state_wdata(wdata),
    .o_s1_upd_vld_r(s_vld[1]), .o_s1_upd_prod_id_r(s_id[1]),
    .o_s2_upd_vld_r(s_vld[2]), .o_s2_upd_prod_id_r(s_id[2]),
    .o_s3_upd_vld_r(s_vld[3]), .o_s3_upd_prod_id_r(s_id[3]),
    .o_s4_upd_vld_r(s_vld[4]), .o_s4_upd_prod_id_r(s_id[4]),
    .o_s5_upd_vld_r(s_vld[5]), .o_s5_upd_prod_id_r(s_id[5])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // State table: one-cycle read latency, read-before-write on a same-edge collision.
  state_t mem [256];
  always @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (ren) rdata <= mem[raddr];
      if (wen) mem[waddr] <= wdata;
    end
  end

  // Reference lists: per ID, keys in descending order with their volumes.
  key_t    mk [256][$];
  volume_t mv [256][$];

  typedef struct {
    int     due;
    int     id;
    bit     err;
    state_t st;
  } exp_t;
  exp_t wq[$];
  exp_t rq[$];
  exp_t e_new;
  exp_t e_cur;
  int   hist [1:5];
  bit   busy;
  bit   a_err;

  task automatic model_apply(input int id, input cmd_t c, input key_t k, input volume_t v,
                             output bit err);
    int idx;
    int pos;
    idx = -1;
    pos = 0;
    for (int i = 0; i < mk[id].size(); i++) begin
      if (mk[id][i] == k) idx = i;
      if (mk[id][i] > k) pos++;
    end
    err = 1'b0;
    case (c)
      CMD_CLEAR: begin
        mk[id].delete();
        mv[id].delete();
      end
      CMD_ADD: begin
        if (idx >= 0 || mk[id].size() >= ENTRIES_N) err = 1'b1;
        else begin
          mk[id].insert(pos, k);
          mv[id].insert(pos, v);
        end
      end
      CMD_DELETE: begin
        if (idx < 0) err = 1'b1;
        else begin
          mk[id].delete(idx);
          mv[id].delete(idx);
        end
      end
      default: begin
        if (idx < 0) err = 1'b1;
        else mv[id][idx] = v;
      end
    endcase
  endtask

  function automatic state_t model_state(input int id);
    state_t s;
    s = '0;
    s.listsize = listsize_t'(mk[id].size());
    for (int i = 0; i < mk[id].size(); i++) begin
      s.vld[i]    = 1'b1;
      s.key[i]    = mk[id][i];
      s.volume[i] = mv[id][i];
    end
    return s;
  endfunction

  function automatic state_t mask_invalid(input state_t s);
    state_t m;
    m = s;
    for (int i = 0; i < ENTRIES_N; i++) begin
      if (!m.vld[i]) begin
        m.key[i]    = '0;
        m.volume[i] = '0;
      end
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (arst) begin
      check("rst_wen", wen, 0);
      check("rst_rsp_vld", rsp_vld, 0);
      check("rst_ren", ren, 0);
      check("rst_stage_vld", s_vld, 0);
      wq.delete();
      rq.delete();
      for (int k = 1; k <= 5; k++) hist[k] = -1;
      for (int i = 0; i < 256; i++) begin
        mk[i].delete();
        mv[i].delete();
      end
    end else begin
      for (int k = 1; k <= 5; k++) begin
        check($sformatf("s%0d_vld", k), s_vld[k], hist[k] >= 0);
        if (hist[k] >= 0) check($sformatf("s%0d_id", k), s_id[k], hist[k]);
      end
      busy = 1'b0;
      for (int k = 1; k <= STALL_LAST; k++) if (hist[k] == int'(upd_id)) busy = 1'b1;
      check("rdy", upd_rdy, !busy);

      if (wq.size() > 0 && wq[0].due == cyc) begin
        e_cur = wq.pop_front();
        check("wen", wen, !e_cur.err);
        if (!e_cur.err) begin
          check("waddr", waddr, e_cur.id);
          check("wdata", mask_invalid(wdata), e_cur.st);
        end
      end else begin
        check("wen_idle", wen, 0);
      end

      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_cur = rq.pop_front();
        check("rsp_vld", rsp_vld, 1);
        check("rsp_id", rsp_id, e_cur.id);
        check("rsp_err", rsp_err, e_cur.err);
      end else begin
        check("rsp_idle", rsp_vld, 0);
      end

      if (upd_vld && upd_rdy) begin
        model_apply(int'(upd_id), upd_cmd, upd_key, upd_vol, a_err);
        e_new.id  = int'(upd_id);
        e_new.err = a_err;
        e_new.st  = model_state(int'(upd_id));
        e_new.due = cyc + 4;
        wq.push_back(e_new);
        e_new.due = cyc + 5;
        rq.push_back(e_new);
      end
      for (int k = 5; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = (upd_vld && upd_rdy) ? int'(upd_id) : -1;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the command.
  task automatic issue(input int id, input cmd_t c, input int key, input int vol,
                       output int waited);
    upd_vld = 1'b1;
    upd_id  = id_t'(id);
    upd_cmd = c;
    upd_key = key_t'(key);
    upd_vol = volume_t'(vol);
    waited  = 0;
    @(negedge clk);
    while (!upd_rdy && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!upd_rdy) check("issue_rdy", upd_rdy, 1);
    @(posedge clk);
    #1;
    upd_vld = 1'b0;
  endtask

  task automatic send(input int id, input cmd_t c, input int key, input int vol);
    int w;
    issue(id, c, key, vol, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int w;
    int r;
    cmd_t c;
    arst    = 1'b1;
    upd_vld = 1'b0;
    upd_id  = '0;
    upd_cmd = CMD_CLEAR;
    upd_key = '0;
    upd_vol = '0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    idle(1);

    send(3, CMD_ADD, 100, 5);
    send(3, CMD_ADD, 90, 1);
    send(3, CMD_ADD, 95, 7);
    send(3, CMD_ADD, 95, 2);
    send(3, CMD_ADD, 80, 3);
    send(3, CMD_ADD, 85, 4);
    send(3, CMD_DELETE, 90, 0);
    send(3, CMD_REPLACE, 80, 9);
    send(3, CMD_REPLACE, 55, 6);
    send(3, CMD_DELETE, 100, 0);
    idle(8);

    issue(3, CMD_ADD, 60, 1, w);
    issue(4, CMD_ADD, 60, 1, w);
    check("diff_id_wait", w, 0);
    issue(3, CMD_DELETE, 60, 0, w);
    check("same_id_wait", w, STALL_LAST - 1);
    idle(8);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      c = (r == 0) ? CMD_CLEAR : (r < 6) ? CMD_ADD : (r < 8) ? CMD_DELETE : CMD_REPLACE;
      send($urandom_range(0, 5), c, $urandom_range(1, 8) * 10, $urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(10);

    send(1, CMD_ADD, 40, 1);
    send(2, CMD_ADD, 40, 2);
    send(5, CMD_ADD, 40, 3);
    arst = 1'b1;
    idle(2);
    arst = 1'b0;
    idle(2);
    send(3, CMD_CLEAR, 0, 0);
    send(3, CMD_ADD, 70, 8);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
